// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcodes, state encoding and select decode for the shared ALU controller
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_MUL     = 3'd2;
  localparam logic [2:0] OP_COUNT   = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_GREATER = 3'd5;

  localparam logic [2:0] OP_LAST_LEGAL = OP_GREATER;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Illegal opcodes decode to an all-zero select so the ALU is never driven by them.
  function automatic logic [5:0] onehot_sel(input logic [2:0] op);
    logic [5:0] sel;
    sel = 6'b000000;
    if (op <= OP_LAST_LEGAL) begin
      sel = 6'b000001 << op;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-request round-robin arbiter with a registered priority pointer
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       update,
  input  logic       ptr_next,
  output logic [1:0] grant
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ptr_next;
    end
  end

  // The pointer only matters on contention; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = ptr ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one MA ALU between two requesters with a settle-timed issue
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [9:0]  req_a,
  input  logic [9:0]  req_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_balance,
  output logic        rsp_equal,
  output logic        rsp_err,
  output logic        busy,
  output logic [4:0]  alu_number1,
  output logic [4:0]  alu_number2,
  output logic [5:0]  alu_printout,
  input  logic [31:0] alu_conclusion,
  input  logic        alu_balancebit,
  input  logic        alu_equalitybit
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic       gnt_q;
  logic [2:0] op_q;
  logic [4:0] a_q;
  logic [4:0] b_q;
  logic [3:0] cnt;

  logic [1:0] grant;
  logic       arb_en;
  logic       accept;
  logic       sel;
  logic       rsp_done;
  logic       ptr_next;
  logic [2:0] op_in;
  logic [4:0] a_in;
  logic [4:0] b_in;

  assign arb_en   = rst_n && (state == ST_IDLE);
  assign accept   = |(req_valid & grant);
  assign sel      = grant[1];
  assign op_in    = sel ? req_op[5:3] : req_op[2:0];
  assign a_in     = sel ? req_a[9:5]  : req_a[4:0];
  assign b_in     = sel ? req_b[9:5]  : req_b[4:0];
  assign rsp_done = (state == ST_RESP) && rsp_ready[gnt_q];
  assign ptr_next = ~gnt_q;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .en       (arb_en),
    .update   (rsp_done),
    .ptr_next (ptr_next),
    .grant    (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gnt_q       <= 1'b0;
      op_q        <= 3'd0;
      a_q         <= 5'd0;
      b_q         <= 5'd0;
      cnt         <= 4'd0;
      rsp_result  <= 32'd0;
      rsp_balance <= 1'b0;
      rsp_equal   <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            gnt_q <= sel;
            op_q  <= op_in;
            a_q   <= a_in;
            b_q   <= b_in;
            if (op_in > OP_LAST_LEGAL) begin
              rsp_result  <= 32'd0;
              rsp_balance <= 1'b0;
              rsp_equal   <= 1'b0;
              rsp_err     <= 1'b1;
              state       <= ST_RESP;
            end else begin
              cnt   <= SETTLE_LOAD;
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (cnt == 4'd0) begin
            rsp_result  <= alu_conclusion;
            rsp_balance <= alu_balancebit;
            rsp_equal   <= alu_equalitybit;
            rsp_err     <= 1'b0;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request/response strobes are masked during reset so no handshake can slip through.
  assign req_ready    = grant;
  assign rsp_valid    = (rst_n && (state == ST_RESP)) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy         = (state != ST_IDLE);
  assign alu_number1  = a_q;
  assign alu_number2  = b_q;
  assign alu_printout = (state == ST_ISSUE) ? onehot_sel(op_q) : 6'b000000;

endmodule
